// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: pipeline-stage occupancy states for the elastic stage register.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with a two-entry skid buffer, registered in_ready,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_skid
  import cpu_types_pkg::*;
#(
  parameter int unsigned          DATA_W = 32,
  parameter logic [DATA_W-1:0]    BUBBLE = '0,
  parameter int unsigned          CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  pipe_state_t       state, state_d;
  logic              push, pop;

  // skid is only ever filled behind a valid main, so skid valid alone means FULL
  always_comb begin
    if (skid_vld_q) begin
      state = FULL;
    end else if (main_vld_q) begin
      state = ONE;
    end else begin
      state = EMPTY;
    end
  end

  assign push = in_valid & rdy_q;
  assign pop  = main_vld_q & out_ready;

  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            main_d = in_data;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    main_vld_d = (state_d != EMPTY);
    skid_vld_d = (state_d == FULL);
    rdy_d      = (state_d != FULL);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_clr) begin
      cnt_d = '0;
    end else if (main_vld_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      cnt_q      <= cnt_d;
    end
  end

  // Payload registers carry no reset; their valid bits qualify them.
  always_ff @(posedge CLK) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_vld_q ? main_q : BUBBLE;
  assign occupancy = {skid_vld_q, main_vld_q & ~skid_vld_q};
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: reference-queue scoreboard plus vector tables
// and hand-written corner-case sequences.
module tb_pipe_stage_skid;

  localparam int unsigned       DW  = 32;
  localparam int unsigned       CW  = 4;
  localparam logic [DW-1:0]     BUB = 32'hDEAD_BEEF;
  localparam logic [CW-1:0]     CMAX = {CW{1'b1}};

  logic          clk;
  logic          nrst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic          stall_clr;

  pipe_stage_skid #(
    .DATA_W (DW),
    .BUBBLE (BUB),
    .CNT_W  (CW)
  ) dut (
    .CLK       (clk),
    .nRST      (nrst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] sb_q[$];
  logic          m_rdy;
  logic [CW-1:0] m_cnt;

  typedef struct {
    logic          iv;
    logic [DW-1:0] idata;
    logic          ordy;
    logic          ev;
    logic [DW-1:0] edata;
    logic [1:0]    eocc;
    logic          erdy;
    logic [CW-1:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares outputs to the model at the negedge, then advances the model across the next edge.
  task automatic cycle();
    logic          m_v;
    logic          push;
    logic          pop;
    @(negedge clk);
    m_v = (sb_q.size() > 0);
    chk("out_valid", 64'(out_valid), 64'(m_v));
    chk("out_data", 64'(out_data), 64'(m_v ? sb_q[0] : BUB));
    chk("occupancy", 64'(occupancy), 64'(sb_q.size()));
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    if (!nrst) begin
      sb_q.delete();
      m_rdy = 1'b1;
      m_cnt = '0;
    end else begin
      push = in_valid && m_rdy;
      pop  = m_v && out_ready;
      if (stall_clr) m_cnt = '0;
      else if (m_v && !out_ready && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
      if (flush) begin
        sb_q.delete();
      end else begin
        if (pop) void'(sb_q.pop_front());
        if (push) sb_q.push_back(in_data);
      end
      m_rdy = (sb_q.size() != 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    sb_q.delete();
    m_rdy = 1'b1;
    m_cnt = '0;
  endtask

  task automatic add_vec(input logic iv, input logic [DW-1:0] idata, input logic ordy,
                         input logic ev, input logic [DW-1:0] edata, input logic [1:0] eocc,
                         input logic erdy, input logic [CW-1:0] ecnt);
    vec_t v;
    v.iv = iv; v.idata = idata; v.ordy = ordy;
    v.ev = ev; v.edata = edata; v.eocc = eocc; v.erdy = erdy; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].idata;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      chk("vec_valid", 64'(out_valid), 64'(vecs[i].ev));
      chk("vec_data", 64'(out_data), 64'(vecs[i].edata));
      chk("vec_occ", 64'(occupancy), 64'(vecs[i].eocc));
      chk("vec_rdy", 64'(in_ready), 64'(vecs[i].erdy));
      chk("vec_cnt", 64'(stall_cnt), 64'(vecs[i].ecnt));
      @(posedge clk);
      #1;
      // keep the reference model in step with the hand-written table
      if (vecs[i].iv && vecs[i].erdy) sb_q.push_back(vecs[i].idata);
      if (vecs[i].ev && vecs[i].ordy) void'(sb_q.pop_front());
      m_rdy = (sb_q.size() != 2);
      m_cnt = vecs[i].ecnt + CW'(vecs[i].ev && !vecs[i].ordy);
    end
    vecs.delete();
  endtask

  initial begin
    nrst = 1'b0;
    idle_inputs();
    sb_q.delete();
    m_rdy = 1'b1;
    m_cnt = '0;

    // Streaming with out_ready high: one-cycle latency, occupancy 1
    do_reset();
    add_vec(1'b1, 32'h1, 1'b1, 1'b0, BUB, 2'd0, 1'b1, 4'd0);
    for (int k = 2; k <= 8; k++) begin
      add_vec(1'b1, DW'(k), 1'b1, 1'b1, DW'(k - 1), 2'd1, 1'b1, 4'd0);
    end
    add_vec(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 2'd1, 1'b1, 4'd0);
    add_vec(1'b0, 32'h0, 1'b1, 1'b0, BUB, 2'd0, 1'b1, 4'd0);
    run_vecs();

    // Stall after the first push, skid fill, then release
    do_reset();
    add_vec(1'b1, 32'hA, 1'b1, 1'b0, BUB,   2'd0, 1'b1, 4'd0);
    add_vec(1'b1, 32'hB, 1'b0, 1'b1, 32'hA, 2'd1, 1'b1, 4'd0);
    add_vec(1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 4'd1);
    add_vec(1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 4'd2);
    add_vec(1'b1, 32'hC, 1'b1, 1'b1, 32'hA, 2'd2, 1'b0, 4'd3);
    add_vec(1'b1, 32'hC, 1'b1, 1'b1, 32'hB, 2'd1, 1'b1, 4'd3);
    add_vec(1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 2'd1, 1'b1, 4'd3);
    add_vec(1'b0, 32'h0, 1'b1, 1'b0, BUB,   2'd0, 1'b1, 4'd3);
    run_vecs();

    // Flush in FULL together with a push: 0x33 must be squashed
    do_reset();
    in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0; cycle();
    in_data = 32'h22; cycle();
    flush = 1'b1; in_data = 32'h33; cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_data", 64'(out_data), 64'(BUB));
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_rdy", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    repeat (3) cycle();

    // Counter saturation and clear-over-increment
    do_reset();
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0; cycle();
    in_valid = 1'b0;
    repeat ((1 << CW) + 5) cycle();
    @(negedge clk);
    chk("cnt_sat", 64'(stall_cnt), 64'(CMAX));
    @(posedge clk); #1;
    stall_clr = 1'b1; cycle();
    stall_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr", 64'(stall_cnt), 64'(0));
    @(posedge clk); #1;

    // Reset while FULL, then first push after release
    do_reset();
    in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b0; cycle();
    in_data = 32'h45; cycle();
    cycle();
    in_valid = 1'b0; nrst = 1'b0; cycle();
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(BUB));
    chk("rst_occ", 64'(occupancy), 64'(0));
    chk("rst_rdy", 64'(in_ready), 64'(1));
    chk("rst_cnt", 64'(stall_cnt), 64'(0));
    @(posedge clk); #1;
    nrst = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1; cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'(1));
    chk("post_rst_data", 64'(out_data), 64'(32'h55));
    @(posedge clk); #1;

    // Random traffic against the reference queue
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      stall_clr = ($urandom_range(0, 31) == 0);
      cycle();
      if (sb_q.size() > 2) chk("model_occ_bound", 64'(sb_q.size()), 64'(2));
    end
    idle_inputs();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
